// File: rtl/trigger_pkg.sv
// trigger_pkg: shared state encoding and default widths for the trigger/stop controller
package trigger_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, DELAY, STOPPED} trig_state_t;
    localparam int CNT_W_DEF  = 8;
    localparam int POS_W_DEF  = 8;
    localparam int MISS_W_DEF = 8;
endpackage

// File: rtl/trigger_edge_detect.sv
// trigger_edge_detect: rising-edge detector on the synchronized trigger level
// TRIG_STOP_2FF_SYNC_EN adds a second metastability flop ahead of the detector.
module trigger_edge_detect (
    input  logic FCLK,
    input  logic RSTB,
    input  logic trig_in,
    output logic trig_edge
);
    logic trig_s;
    logic trig_d;
`ifdef TRIG_STOP_2FF_SYNC_EN
    always_ff @(posedge FCLK or negedge RSTB)
        if (!RSTB) trig_s <= 1'b0;
        else       trig_s <= trig_in;
`else
    assign trig_s = trig_in;
`endif
    always_ff @(posedge FCLK or negedge RSTB)
        if (!RSTB) trig_d <= 1'b0;
        else       trig_d <= trig_s;
    assign trig_edge = trig_s & ~trig_d;
endmodule

// File: rtl/trigger_stop_ctrl.sv
// trigger_stop_ctrl: arms on request, stops sampling a programmable delay after the trigger edge
// and hands the captured write position to readout (TRIG_STOP_2FF_SYNC_EN adds one sync stage).
module trigger_stop_ctrl
    import trigger_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int POS_W  = POS_W_DEF,
    parameter int MISS_W = MISS_W_DEF
) (
    input  logic              FCLK,
    input  logic              RSTB,
    input  logic              trigger_sync,
    input  logic              arm,
    input  logic [CNT_W-1:0]  delay,
    input  logic [POS_W-1:0]  sample_pos,
    input  logic              trig_ack,
    output logic              stop,
    output logic [POS_W-1:0]  trig_pos,
    output logic              trig_valid,
    output logic              armed,
    output logic [MISS_W-1:0] miss_cnt
);
    trig_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             trig_edge;

    trigger_edge_detect u_edge (
        .FCLK      (FCLK),
        .RSTB      (RSTB),
        .trig_in   (trigger_sync),
        .trig_edge (trig_edge)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arm ? ARMED : IDLE;
            ARMED:   state_nxt = trig_edge ? ((delay == '0) ? STOPPED : DELAY) : ARMED;
            DELAY:   state_nxt = (cnt == '0) ? STOPPED : DELAY;
            STOPPED: state_nxt = trig_ack ? (arm ? ARMED : IDLE) : STOPPED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            state    <= IDLE;
            cnt      <= '0;
            trig_pos <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARMED && trig_edge) begin
                trig_pos <= sample_pos;
                cnt      <= (delay == '0) ? '0 : delay - CNT_W'(1);
            end else if (state == DELAY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // only an edge that cannot start a capture counts as missed
            if (trig_edge && state != ARMED && !(&miss_cnt))
                miss_cnt <= miss_cnt + MISS_W'(1);
        end
    end

    assign stop       = (state == STOPPED);
    assign trig_valid = (state == STOPPED);
    assign armed      = (state == ARMED);
endmodule

// File: tb/tb_trigger_stop_ctrl.sv
// tb_trigger_stop_ctrl: directed self-checking bench for trigger_stop_ctrl
// Latencies follow TRIG_STOP_2FF_SYNC_EN when the build defines it.
`timescale 1ns/100ps
module tb_trigger_stop_ctrl;
`ifdef TRIG_STOP_2FF_SYNC_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    logic       FCLK = 1'b0;
    logic       RSTB = 1'b0;
    logic       trigger_sync = 1'b0;
    logic       arm = 1'b0;
    logic [7:0] delay = 8'd0;
    logic [7:0] sample_pos = 8'd0;
    logic       trig_ack = 1'b0;
    logic       stop;
    logic [7:0] trig_pos;
    logic       trig_valid;
    logic       armed;
    logic [7:0] miss_cnt;
    int vectors = 0;
    int miscompares = 0;

    trigger_stop_ctrl dut (
        .FCLK         (FCLK),
        .RSTB         (RSTB),
        .trigger_sync (trigger_sync),
        .arm          (arm),
        .delay        (delay),
        .sample_pos   (sample_pos),
        .trig_ack     (trig_ack),
        .stop         (stop),
        .trig_pos     (trig_pos),
        .trig_valid   (trig_valid),
        .armed        (armed),
        .miss_cnt     (miss_cnt)
    );

    always #1 FCLK = ~FCLK;

    task automatic tick();
        @(negedge FCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        trigger_sync = 1'b1;
        tick();
        trigger_sync = 1'b0;
        tick();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_stop", stop, 0);
        chk("rst_valid", trig_valid, 0);
        chk("rst_pos", trig_pos, 0);
        chk("rst_armed", armed, 0);
        chk("rst_miss", miss_cnt, 0);
        RSTB = 1'b1;
        tick();
        // delay=5, position 0x3A, trigger level held 20 cycles
        do_arm();
        chk("armed_after_arm", armed, 1);
        delay = 8'd5;
        sample_pos = 8'h3A;
        trigger_sync = 1'b1;
        tick();
        sample_pos = 8'h44;
        chk("d5_armed_drop", armed, 0);
        for (int k = 2; k <= 5 + XL; k++) tick();
        chk("d5_stop_early", stop, 0);
        chk("d5_valid_early", trig_valid, 0);
        tick();
        chk("d5_stop", stop, 1);
        chk("d5_valid", trig_valid, 1);
        chk("d5_pos", trig_pos, 8'h3A);
        repeat (14 - XL) tick();
        chk("hold_level_miss", miss_cnt, 0);
        chk("hold_level_pos", trig_pos, 8'h3A);
        trigger_sync = 1'b0;
        tick();
        // edges while stopped only count as misses; arm without ack ignored
        repeat (3) pulse();
        chk("stopped_miss3", miss_cnt, 3);
        chk("stopped_pos_held", trig_pos, 8'h3A);
        do_arm();
        chk("arm_no_ack_stop", stop, 1);
        chk("arm_no_ack_armed", armed, 0);
        trig_ack = 1'b1;
        tick();
        trig_ack = 1'b0;
        chk("ack_stop", stop, 0);
        chk("ack_valid", trig_valid, 0);
        chk("ack_armed", armed, 0);
        trig_ack = 1'b1;
        tick();
        trig_ack = 1'b0;
        chk("idle_ack_armed", armed, 0);
        // delay=0: stop at T+1, ack at T+4 drops stop at T+5
        do_arm();
        delay = 8'd0;
        sample_pos = 8'h10;
        trigger_sync = 1'b1;
        repeat (1 + XL) tick();
        trigger_sync = 1'b0;
        chk("d0_stop", stop, 1);
        chk("d0_valid", trig_valid, 1);
        chk("d0_pos", trig_pos, 8'h10);
        repeat (3) tick();
        trig_ack = 1'b1;
        tick();
        trig_ack = 1'b0;
        chk("d0_ack_stop", stop, 0);
        chk("d0_ack_valid", trig_valid, 0);
        // ack and arm together re-arm directly, next edge captures new position
        do_arm();
        sample_pos = 8'h55;
        trigger_sync = 1'b1;
        repeat (1 + XL) tick();
        trigger_sync = 1'b0;
        chk("rearm_pre_stop", stop, 1);
        chk("rearm_pre_pos", trig_pos, 8'h55);
        trig_ack = 1'b1;
        arm = 1'b1;
        tick();
        trig_ack = 1'b0;
        arm = 1'b0;
        chk("ackarm_armed", armed, 1);
        chk("ackarm_stop", stop, 0);
        sample_pos = 8'h77;
        trigger_sync = 1'b1;
        repeat (1 + XL) tick();
        trigger_sync = 1'b0;
        chk("rearm_pos", trig_pos, 8'h77);
        chk("rearm_stop", stop, 1);
        trig_ack = 1'b1;
        tick();
        trig_ack = 1'b0;
        // delay input changed mid-DELAY must not alter the countdown
        do_arm();
        delay = 8'd10;
        sample_pos = 8'h21;
        trigger_sync = 1'b1;
        tick();
        delay = 8'd2;
        for (int k = 2; k <= 10 + XL; k++) tick();
        chk("d10_stop_early", stop, 0);
        tick();
        chk("d10_stop", stop, 1);
        chk("d10_pos", trig_pos, 8'h21);
        trigger_sync = 1'b0;
        trig_ack = 1'b1;
        tick();
        trig_ack = 1'b0;
        chk("miss_before_rst", miss_cnt, 3);
        // asynchronous reset in the middle of a delay
        do_arm();
        delay = 8'd20;
        sample_pos = 8'h99;
        trigger_sync = 1'b1;
        repeat (3 + XL) tick();
        chk("pre_rst_pos", trig_pos, 8'h99);
        RSTB = 1'b0;
        trigger_sync = 1'b0;
        #0.2;
        chk("arst_stop", stop, 0);
        chk("arst_valid", trig_valid, 0);
        chk("arst_pos", trig_pos, 0);
        chk("arst_armed", armed, 0);
        chk("arst_miss", miss_cnt, 0);
        tick();
        RSTB = 1'b1;
        tick();
        repeat (5) pulse();
        chk("unarmed_miss5", miss_cnt, 5);
        chk("unarmed_stop", stop, 0);
        // saturation of the missed-trigger counter
        repeat (249) pulse();
        chk("miss_254", miss_cnt, 8'd254);
        pulse();
        chk("miss_255", miss_cnt, 8'hFF);
        repeat (60) pulse();
        chk("miss_sat", miss_cnt, 8'hFF);
        chk("sat_stop", stop, 0);
        chk("sat_valid", trig_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
